imem_loader: RTL

//   Write side of the instruction memory. Receives a byte stream over a valid/ready

---
 rtl/imem_loader.sv | 83 ++++++++
 1 files changed

// File: rtl/imem_loader.sv
// imem_loader: assembles a length-prefixed little-endian byte stream into 32-bit IM writes, holding the core until done
module imem_loader #(
  parameter int DEPTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  output logic             in_ready,
  output logic             imem_we,
  output logic [31:0]      imem_addr,
  output logic [31:0]      imem_wdata,
  output logic             cpu_hold,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] words_loaded
);
  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] LEN_LO = 3'd1;
  localparam logic [2:0] LEN_HI = 3'd2;
  localparam logic [2:0] DATA   = 3'd3;
  localparam logic [2:0] WRITE  = 3'd4;
  localparam logic [2:0] DONE   = 3'd5;
  localparam logic [2:0] ERR    = 3'd6;
  logic [2:0]       state;
  logic [CNT_W-1:0] len;
  logic [CNT_W-1:0] n_hdr;
  logic [7:0]       len_lo;
  logic [1:0]       byte_idx;
  logic [23:0]      part;
  logic             acc;
  assign in_ready = state == LEN_LO || state == LEN_HI || state == DATA;
  assign imem_we  = state == WRITE;
  assign done     = state == DONE;
  assign err      = state == ERR;
  assign cpu_hold = state != DONE;
  assign acc      = in_valid && in_ready;
  assign n_hdr    = CNT_W'({in_data, len_lo});
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      len          <= '0;
      len_lo       <= '0;
      byte_idx     <= '0;
      part         <= '0;
      imem_addr    <= '0;
      imem_wdata   <= '0;
      words_loaded <= '0;
    end else begin
      case (state)
        IDLE, DONE, ERR: if (start) begin
          state        <= LEN_LO;
          words_loaded <= '0;
          byte_idx     <= '0;
        end
        LEN_LO: if (acc) begin
          len_lo <= in_data;
          state  <= LEN_HI;
        end
        LEN_HI: if (acc) begin
          len   <= n_hdr;
          state <= n_hdr == '0 ? DONE : n_hdr > CNT_W'(DEPTH) ? ERR : DATA;
        end
        DATA: if (acc) begin
          byte_idx <= byte_idx + 2'd1;
          part     <= {in_data, part[23:8]};
          if (byte_idx == 2'd3) begin
            imem_wdata <= {in_data, part};
            imem_addr  <= 32'(words_loaded) << 2;
            state      <= WRITE;
          end
        end
        WRITE: begin
          words_loaded <= words_loaded + 1'b1;
          state        <= words_loaded + 1'b1 == len ? DONE : DATA;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
